// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a synchronous FIFO one word at a time onto a UART-style TX line.
// Ports: clk, rst_n, enable, fifo_empty/fifo_pop/fifo_dout, tx, busy, frame_done, frame_count.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             fifo_empty,
  output logic             fifo_pop,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             tx,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      frame_count
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    baud_q, baud_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_q, par_d;
  logic [15:0]      frame_cnt_q;

  logic can_go;
  logic bit_end;
  logic last_stop;

  assign can_go  = enable && !fifo_empty;
  assign bit_end = (baud_q == CW'(CLKS_PER_BIT - 1));

  // bit_q doubles as the stop-bit index while in STOP
  assign last_stop = (state_q == STOP) && bit_end
                  && (bit_q == BW'(STOP_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      if (last_stop) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = '0;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx      = 1'b1;
    unique case (state_q)
      IDLE: begin
        bit_d = '0;
        if (can_go) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d = fifo_dout;
        par_d   = (^fifo_dout) ^ (PARITY_ODD != 0);
        bit_d   = '0;
        state_d = START;
      end
      START: begin
        tx     = 1'b0;
        baud_d = bit_end ? '0 : baud_q + CW'(1);
        if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        tx     = shift_q[0];
        baud_d = bit_end ? '0 : baud_q + CW'(1);
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BW'(WIDTH - 1)) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      PARITY: begin
        tx     = par_q;
        baud_d = bit_end ? '0 : baud_q + CW'(1);
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        baud_d = bit_end ? '0 : baud_q + CW'(1);
        if (bit_end) begin
          if (bit_q == BW'(STOP_BITS - 1)) begin
            bit_d   = '0;
            state_d = can_go ? FETCH : IDLE;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fifo_pop    = (state_q == FETCH);
  assign busy        = (state_q != IDLE);
  assign frame_done  = last_stop;
  assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx with a behavioural FIFO per instance.
// Instances: u0 defaults, u1 even parity, u2 odd parity, u3 two stop bits (all 4 clks/bit).
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en   [4];
  logic        emp  [4];
  logic        pop  [4];
  logic [7:0]  dout [4];
  logic        tx   [4];
  logic        busy [4];
  logic        done [4];
  logic [15:0] fc   [4];

  logic [7:0] mem [4][16];
  int wr   [4] = '{default: 0};
  int rd   [4] = '{default: 0};
  int pops [4] = '{default: 0};

  int checks = 0;
  int fails  = 0;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      emp[i] = (wr[i] == rd[i]);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pop[i]) begin
        pops[i] <= pops[i] + 1;
        if (wr[i] != rd[i]) begin
          dout[i] <= mem[i][rd[i] % 16];
          rd[i]   <= rd[i] + 1;
        end
      end
    end
  end

  fifo_uart_tx #(.CLKS_PER_BIT(4)) u0 (
    .clk(clk), .rst_n(rst_n), .enable(en[0]),
    .fifo_empty(emp[0]), .fifo_pop(pop[0]),
    .fifo_dout(dout[0]), .tx(tx[0]), .busy(busy[0]),
    .frame_done(done[0]), .frame_count(fc[0])
  );

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) u1 (
    .clk(clk), .rst_n(rst_n), .enable(en[1]),
    .fifo_empty(emp[1]), .fifo_pop(pop[1]),
    .fifo_dout(dout[1]), .tx(tx[1]), .busy(busy[1]),
    .frame_done(done[1]), .frame_count(fc[1])
  );

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1),
                 .PARITY_ODD(1)) u2 (
    .clk(clk), .rst_n(rst_n), .enable(en[2]),
    .fifo_empty(emp[2]), .fifo_pop(pop[2]),
    .fifo_dout(dout[2]), .tx(tx[2]), .busy(busy[2]),
    .frame_done(done[2]), .frame_count(fc[2])
  );

  fifo_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u3 (
    .clk(clk), .rst_n(rst_n), .enable(en[3]),
    .fifo_empty(emp[3]), .fifo_pop(pop[3]),
    .fifo_dout(dout[3]), .tx(tx[3]), .busy(busy[3]),
    .frame_done(done[3]), .frame_count(fc[3])
  );

  task automatic push(input int i, input logic [7:0] d);
    mem[i][wr[i] % 16] = d;
    wr[i] = wr[i] + 1;
  endtask

  // Waits for the start bit, then records tx/frame_done/busy every
  // cycle of the frame. Returns with the last stop cycle current.
  task automatic check_frame(input int i, input logic [7:0] d,
                             input bit pen, input bit pbit,
                             input int nstop, input string nm,
                             output int lat);
    logic [63:0] etx, otx, edn, odn, ebz, obz;
    int nb, len, b;
    etx = '0; otx = '0; edn = '0;
    odn = '0; ebz = '0; obz = '0;
    nb  = 1 + 8 + int'(pen) + nstop;
    len = nb * 4;
    lat = 0;
    while (tx[i] !== 1'b0 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 200) begin
      checks++;
      fails++;
      $display("FAIL %s start timeout got no start want start", nm);
      return;
    end
    for (int j = 0; j < len; j++) begin
      b = j / 4;
      if (b == 0) etx[j] = 1'b0;
      else if (b <= 8) etx[j] = d[b-1];
      else if (pen && b == 9) etx[j] = pbit;
      else etx[j] = 1'b1;
      edn[j] = (j == len - 1);
      ebz[j] = 1'b1;
      otx[j] = tx[i];
      odn[j] = done[i];
      obz[j] = busy[i];
      if (j < len - 1) @(negedge clk);
    end
    checks++;
    if (otx !== etx) begin
      fails++;
      $display("FAIL %s tx got %h want %h", nm, otx, etx);
    end
    checks++;
    if (odn !== edn) begin
      fails++;
      $display("FAIL %s frame_done got %h want %h", nm, odn, edn);
    end
    checks++;
    if (obz !== ebz) begin
      fails++;
      $display("FAIL %s busy got %h want %h", nm, obz, ebz);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) en[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({tx[i], busy[i], pop[i], done[i], fc[i]} !==
          {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
        fails++;
        $display("FAIL reset u%0d got %b%b%b%b %h want 1000 0000",
                 i, tx[i], busy[i], pop[i], done[i], fc[i]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    int lat, p0;
    p0 = pops[0];
    push(0, 8'hA5);
    en[0] = 1'b1;
    check_frame(0, 8'hA5, 1'b0, 1'b0, 1, "single", lat);
    checks++;
    if (lat !== 3) begin
      fails++;
      $display("FAIL single latency got %0d want 3", lat);
    end
    @(negedge clk);
    en[0] = 1'b0;
    checks++;
    if ({busy[0], tx[0], fc[0]} !== {1'b0, 1'b1, 16'd1}) begin
      fails++;
      $display("FAIL single end got %b%b %h want 01 0001",
               busy[0], tx[0], fc[0]);
    end
    checks++;
    if (pops[0] - p0 !== 1) begin
      fails++;
      $display("FAIL single pops got %0d want 1", pops[0] - p0);
    end
  endtask

  task automatic test_parity;
    int lat;
    push(1, 8'h07);
    en[1] = 1'b1;
    check_frame(1, 8'h07, 1'b1, 1'b1, 1, "even", lat);
    @(negedge clk);
    en[1] = 1'b0;
    checks++;
    if ({busy[1], fc[1]} !== {1'b0, 16'd1}) begin
      fails++;
      $display("FAIL even end got %b %h want 0 0001", busy[1], fc[1]);
    end
    push(2, 8'h07);
    en[2] = 1'b1;
    check_frame(2, 8'h07, 1'b1, 1'b0, 1, "odd", lat);
    @(negedge clk);
    en[2] = 1'b0;
    checks++;
    if ({busy[2], fc[2]} !== {1'b0, 16'd1}) begin
      fails++;
      $display("FAIL odd end got %b %h want 0 0001", busy[2], fc[2]);
    end
  endtask

  task automatic test_back_to_back;
    int lat, p0;
    p0 = pops[0];
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    en[0] = 1'b1;
    check_frame(0, 8'h11, 1'b0, 1'b0, 1, "b2b0", lat);
    check_frame(0, 8'h22, 1'b0, 1'b0, 1, "b2b1", lat);
    checks++;
    if (lat !== 3) begin
      fails++;
      $display("FAIL b2b gap1 got %0d want 3", lat);
    end
    check_frame(0, 8'h33, 1'b0, 1'b0, 1, "b2b2", lat);
    checks++;
    if (lat !== 3) begin
      fails++;
      $display("FAIL b2b gap2 got %0d want 3", lat);
    end
    @(negedge clk);
    en[0] = 1'b0;
    checks++;
    if ({busy[0], fc[0]} !== {1'b0, 16'd4}) begin
      fails++;
      $display("FAIL b2b end got %b %h want 0 0004", busy[0], fc[0]);
    end
    checks++;
    if ((pops[0] - p0 !== 3) || (wr[0] != rd[0])) begin
      fails++;
      $display("FAIL b2b pops got %0d left %0d want 3 left 0",
               pops[0] - p0, wr[0] - rd[0]);
    end
  endtask

  task automatic test_enable_gating;
    int lat, p0, bad;
    p0 = pops[0];
    bad = 0;
    push(0, 8'h3C);
    push(0, 8'hC3);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || pop[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0 || pops[0] !== p0) begin
      fails++;
      $display("FAIL gate idle got %0d bad cycles want 0", bad);
    end
    en[0] = 1'b1;
    @(negedge clk);
    en[0] = 1'b0;
    check_frame(0, 8'h3C, 1'b0, 1'b0, 1, "gate", lat);
    checks++;
    if (lat !== 2) begin
      fails++;
      $display("FAIL gate latency got %0d want 2", lat);
    end
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0 || pops[0] - p0 !== 1 || wr[0] - rd[0] !== 1) begin
      fails++;
      $display("FAIL gate after got bad %0d pops %0d left %0d want 0 1 1",
               bad, pops[0] - p0, wr[0] - rd[0]);
    end
  endtask

  task automatic test_stop2_wrap;
    int lat;
    force u3.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release u3.frame_cnt_q;
    @(negedge clk);
    checks++;
    if (fc[3] !== 16'hFFFF) begin
      fails++;
      $display("FAIL wrap preset got %h want ffff", fc[3]);
    end
    push(3, 8'h81);
    en[3] = 1'b1;
    check_frame(3, 8'h81, 1'b0, 1'b0, 2, "stop2", lat);
    @(negedge clk);
    en[3] = 1'b0;
    checks++;
    if ({busy[3], fc[3]} !== {1'b0, 16'h0000}) begin
      fails++;
      $display("FAIL wrap end got %b %h want 0 0000", busy[3], fc[3]);
    end
  endtask

  task automatic test_reset_mid;
    int lat, k;
    en[0] = 1'b1;
    k = 0;
    while (tx[0] !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (17) @(negedge clk);
    checks++;
    if ({busy[0], tx[0]} !== {1'b1, 1'b0}) begin
      fails++;
      $display("FAIL mid bit3 got %b%b want 10", busy[0], tx[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx[0], busy[0], pop[0], fc[0]} !==
        {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      fails++;
      $display("FAIL async reset got %b%b%b %h want 100 0000",
               tx[0], busy[0], pop[0], fc[0]);
    end
    push(0, 8'h5A);
    @(negedge clk);
    rst_n = 1'b1;
    check_frame(0, 8'h5A, 1'b0, 1'b0, 1, "after_rst", lat);
    checks++;
    if (lat !== 3) begin
      fails++;
      $display("FAIL after_rst latency got %0d want 3", lat);
    end
    @(negedge clk);
    en[0] = 1'b0;
    checks++;
    if ({busy[0], fc[0]} !== {1'b0, 16'd1}) begin
      fails++;
      $display("FAIL after_rst end got %b %h want 0 0001",
               busy[0], fc[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_enable_gating();
    test_stop2_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
